// File: rtl/aes_cipher_multikey.sv
// aes_cipher_multikey: iterative AES-128/192/256 encryption core with valid/ready handshakes
module sub_bytes (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s, v;
    s = gmul(a, a);
    v = s;
    for (int i = 0; i < 6; i++) begin
      s = gmul(s, s);
      v = gmul(v, s);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction
  for (genvar i = 0; i < 16; i++) begin : g_b
    assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
  end
endmodule

module shift_rows (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  for (genvar c = 0; c < 4; c++) begin : g_c
    for (genvar r = 0; r < 4; r++) begin : g_r
      assign dout[127-8*(4*c+r) -: 8] = din[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end
endmodule

module mix_columns (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] mix(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
  for (genvar c = 0; c < 4; c++) begin : g_c
    assign dout[127-32*c -: 32] = mix(din[127-32*c -: 32]);
  end
endmodule

module aes_cipher_multikey #(
  parameter int NR_MAX = 14,
  parameter int RK_W   = (NR_MAX + 1) * 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    data_in,
  input  logic [1:0]      key_size,
  input  logic [RK_W-1:0] round_keys,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    data_out,
  output logic            out_err,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} st_t;
  st_t          st, st_n;
  logic [3:0]   round, round_n, nr, nr_n, nr_sel;
  logic [127:0] state, state_n, dout_n, sb, sr, mc, rk;
  logic         ov_n, oe_n, err, err_n, bad;
  logic [127:0] rk_arr [NR_MAX+1];
  for (genvar r = 0; r <= NR_MAX; r++) begin : g_rk
    assign rk_arr[r] = round_keys[RK_W-1-128*r -: 128];
  end
  sub_bytes   u_sb (.din(state), .dout(sb));
  shift_rows  u_sr (.din(sb), .dout(sr));
  mix_columns u_mc (.din(sr), .dout(mc));
  assign rk       = rk_arr[round];
  assign nr_sel   = key_size == 2'd0 ? 4'd10 : key_size == 2'd1 ? 4'd12 : 4'd14;
  assign bad      = key_size == 2'd3 || int'(nr_sel) > NR_MAX;
  assign in_ready = st == IDLE;
  assign busy     = st != IDLE;
  always_comb begin
    st_n    = st;
    round_n = round;
    state_n = state;
    dout_n  = data_out;
    ov_n    = out_valid;
    oe_n    = out_err;
    nr_n    = nr;
    err_n   = err;
    case (st)
      IDLE: if (in_valid) begin
        st_n    = ROUND;
        nr_n    = bad ? 4'd1 : nr_sel;
        err_n   = bad;
        state_n = data_in ^ rk_arr[0];
        round_n = 4'd1;
      end
      ROUND: if (err) begin
        st_n   = DONE;
        ov_n   = 1'b1;
        oe_n   = 1'b1;
        dout_n = '0;
      end else if (round == nr) begin
        st_n    = DONE;
        state_n = sr ^ rk;
        dout_n  = sr ^ rk;
        ov_n    = 1'b1;
        oe_n    = 1'b0;
      end else begin
        state_n = mc ^ rk;
        round_n = round + 4'd1;
      end
      DONE: if (out_ready) begin
        st_n = IDLE;
        ov_n = 1'b0;
      end
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= IDLE;
      round     <= '0;
      state     <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      nr        <= '0;
      err       <= 1'b0;
    end else begin
      st        <= st_n;
      round     <= round_n;
      state     <= state_n;
      data_out  <= dout_n;
      out_valid <= ov_n;
      out_err   <= oe_n;
      nr        <= nr_n;
      err       <= err_n;
    end
  end
endmodule

// File: doc/aes_cipher_multikey.md
AES_CIPHER_MULTIKEY -- requirements
Module: aes_cipher_multikey

Interface
REQ-001 The block SHALL have parameter NR_MAX, default 14, meaning the maximum supported round count (legal values 10, 12, 14).
REQ-002 The block SHALL have parameter RK_W, default (NR_MAX+1)*128, meaning the width of the round-key bus (derived, not overridden).
REQ-003 clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  the input block is present.
REQ-006 in_ready  output  1  the block can accept an input block.
REQ-007 data_in  input  128  plaintext block.
REQ-008 key_size  input  2  key size: 0=AES-128 (Nr=10), 1=AES-192 (Nr=12), 2=AES-256 (Nr=14), 3=reserved.
REQ-009 round_keys  input  RK_W  expanded keys; round key r occupies bits [RK_W-1-128*r -: 128].
REQ-010 out_valid  output  1  data_out/out_err hold a result.
REQ-011 out_ready  input  1  the downstream accepts the result.
REQ-012 data_out  output  128  ciphertext block.
REQ-013 out_err  output  1  the result is invalid because of an illegal key_size.
REQ-014 busy  output  1  the block is not in IDLE.

Function
REQ-015 The block SHALL implement a three-state FSM with states IDLE, ROUND and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE, and busy SHALL be 1 in ROUND and DONE.
REQ-017 An input is accepted on a rising edge where in_valid=1 and in_ready=1; on that edge the block SHALL latch Nr from key_size, load state = data_in ^ rk[0], set round counter = 1 and enter ROUND.
REQ-018 In ROUND with round < Nr, each edge SHALL apply state = MixColumns(ShiftRows(SubBytes(state))) ^ rk[round] and increment round.
REQ-019 In ROUND with round = Nr, the edge SHALL apply state = ShiftRows(SubBytes(state)) ^ rk[Nr], load data_out, set out_valid=1 and enter DONE.
REQ-020 The latency from the accept edge to out_valid high SHALL be exactly Nr cycles: 10, 12 or 14.
REQ-021 The SubBytes, ShiftRows and MixColumns transforms SHALL be the team's existing sub_bytes, shift_rows and mix_columns modules, with a single instance each (an iterative datapath).
REQ-022 round_keys SHALL be sampled each round and is not latched; the source SHALL hold it stable from the accept edge until out_valid.
REQ-023 In DONE, data_out, out_err and out_valid SHALL hold while out_ready=0, giving unlimited backpressure.
REQ-024 In DONE with out_ready=1, the edge SHALL clear out_valid and enter IDLE.
REQ-025 in_ready SHALL be 1 on the cycle after the handshake, so back-to-back throughput is one block per Nr+2 cycles.
REQ-026 key_size=3, or a key_size whose Nr exceeds NR_MAX, SHALL be accepted normally but SHALL skip ROUND: on the next edge the block enters DONE with out_valid=1, out_err=1 and data_out=0.
REQ-027 out_err SHALL be 0 for every legal result.
REQ-028 in_valid while busy SHALL be ignored, with no effect on the datapath.
REQ-029 Changes to data_in or key_size after the accept edge SHALL NOT affect the result.
REQ-030 out_ready while out_valid=0 SHALL have no effect.
REQ-031 The round counter SHALL be 4 bits wide and SHALL never exceed NR_MAX.

Reset
REQ-032 reset=1 at a rising edge SHALL force IDLE, round=0, state=0, data_out=0, out_valid=0, out_err=0, busy=0 and in_ready=1, with effect from that edge.
REQ-033 reset SHALL take priority over every handshake.
REQ-034 Reset mid-ROUND or in DONE SHALL abandon the block with no output produced.
REQ-035 The first accept SHALL be possible on the first edge after reset deasserts.

Verification
REQ-036 AES-128: data_in=00112233445566778899aabbccddeeff, key 000102..0f expanded, key_size=0 -> out_valid 10 cycles after accept, data_out=69c4e0d86a7b0430d8cdb78070b4c55a, out_err=0.
REQ-037 AES-192 and AES-256: same plaintext, key 00..17 (key_size=1) and key 00..1f (key_size=2) -> data_out=dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles, and data_out=8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
REQ-038 Backpressure: hold out_ready=0 for 20 cycles after out_valid -> data_out stable, in_ready=0 and further in_valid ignored; out_ready=1 -> IDLE next cycle, and a second block accepted immediately completes correctly.
REQ-039 Illegal mode: key_size=3 -> out_valid one cycle after accept, out_err=1, data_out=0; the same check applies with NR_MAX=10 and key_size=2.
REQ-040 Reset mid-operation: assert reset at round 5 of an AES-256 run -> all outputs 0 and in_ready=1 next cycle; a fresh AES-128 vector then passes.
